// File: rtl/pisor_pkg.sv
// Shared types and defaults for the pisor parallel-in/serial-out transmitter.
package pisor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pisor_state_t;

  localparam int PISOR_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/pisor_hold.sv
// One-word holding register between the load handshake and the shifter.
// Set and clear never coincide: set needs it empty, clear needs it full.
module pisor_hold
  import pisor_pkg::*;
#(
  parameter int WIDTH = PISOR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_set,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_hold_q,
  output logic             o_hold_full
);

  logic [WIDTH-1:0] r_hold_q;
  logic             r_hold_full;

  // Capture an accepted word and track occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_q    <= '0;
      r_hold_full <= 1'b0;
    end else if (i_set) begin
      r_hold_q    <= i_din;
      r_hold_full <= 1'b1;
    end else if (i_clr) begin
      r_hold_full <= 1'b0;
    end
  end

  assign o_hold_q    = r_hold_q;
  assign o_hold_full = r_hold_full;

endmodule

// File: rtl/pisor_8.sv
// Parallel-in, serial-out transmitter: MSB first, one bit per clock,
// with a holding register so a refilled word follows without a gap.
module pisor_8
  import pisor_pkg::*;
#(
  parameter int WIDTH = PISOR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_en,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  pisor_state_t     r_state;
  pisor_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_hold_q;
  logic             w_hold_full;
  logic             w_accept;
  logic             w_take;
  logic             w_last;

  assign w_accept   = load_valid && !w_hold_full;
  assign load_ready = !w_hold_full;
  assign w_last     = (r_cnt == CNT_LAST);
  assign busy       = (r_state == SHIFT) || w_hold_full;

  pisor_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_set       (w_accept),
    .i_clr       (w_take),
    .i_din       (din),
    .o_hold_q    (w_hold_q),
    .o_hold_full (w_hold_full)
  );

  // Next-state, shifter/counter update and serial outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    sout        = 1'b0;
    sout_en     = 1'b0;
    word_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hold_full) begin
          w_take      = 1'b1;
          w_shreg_nxt = w_hold_q;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        sout    = r_shreg[WIDTH-1];
        sout_en = 1'b1;
        if (w_last) begin
          word_done = 1'b1;
          // A word already waiting is chained in with no idle cycle.
          if (w_hold_full) begin
            w_take      = 1'b1;
            w_shreg_nxt = w_hold_q;
            w_cnt_nxt   = '0;
            w_state_nxt = SHIFT;
          end else begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end else begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, shift register and bit counter; reset drops any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pisor_8.sv
// Directed self-checking bench for pisor_8 (WIDTH=8 and a WIDTH=4 build).
module tb_pisor_8;

  logic       clk;
  logic       reset_n;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready, sout, sout_en, word_done, busy;
  logic [3:0] d4_din;
  logic       d4_valid;
  logic       d4_ready, d4_sout, d4_sout_en, d4_done, d4_busy;

  int n_checks;
  int n_errors;

  logic [7:0] q_words[$];
  logic       cap_en[64];
  logic       cap_bit[64];
  logic       cap_done[64];
  int         blocked;

  int          first, runlen, ndone;
  logic [31:0] bits, dones;

  pisor_8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_en    (sout_en),
    .word_done  (word_done),
    .busy       (busy)
  );

  pisor_8 #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (d4_din),
    .load_valid (d4_valid),
    .load_ready (d4_ready),
    .sout       (d4_sout),
    .sout_en    (d4_sout_en),
    .word_done  (d4_done),
    .busy       (d4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sout"},       {31'd0, sout},       32'd0);
    check({tag, ".sout_en"},    {31'd0, sout_en},    32'd0);
    check({tag, ".word_done"},  {31'd0, word_done},  32'd0);
    check({tag, ".busy"},       {31'd0, busy},       32'd0);
    check({tag, ".load_ready"}, {31'd0, load_ready}, 32'd1);
  endtask

  // Drive queued words through the handshake; capture outputs at each negedge.
  task automatic run_stream(input int ncyc);
    logic lr_prev;
    lr_prev = 1'b0;
    blocked = 0;
    for (int k = 0; k < 64; k++) begin
      cap_en[k] = 1'b0; cap_bit[k] = 1'b0; cap_done[k] = 1'b0;
    end
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (load_valid && lr_prev) void'(q_words.pop_front());
      cap_en[k]   = sout_en;
      cap_bit[k]  = sout;
      cap_done[k] = word_done;
      lr_prev     = load_ready;
      if (q_words.size() > 0) begin
        load_valid = 1'b1;
        din        = q_words[0];
        if (!load_ready) blocked++;
      end else begin
        load_valid = 1'b0;
      end
    end
  endtask

  // Receiver model: shift in sout on every sout_en cycle of the first run.
  task automatic analyze();
    first = -1; runlen = 0; ndone = 0; bits = 32'd0; dones = 32'd0;
    for (int k = 0; k < 64; k++) begin
      if (cap_en[k] && first < 0) first = k;
      if (cap_done[k]) ndone++;
    end
    if (first >= 0) begin
      for (int j = first; j < 64; j++) begin
        if (!cap_en[j]) break;
        runlen++;
        bits  = {bits[30:0], cap_bit[j]};
        dones = {dones[30:0], cap_done[j]};
      end
    end
  endtask

  initial begin
    logic [3:0] exp4;
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; din = 8'h00; load_valid = 1'b0;
    d4_din = 4'h0; d4_valid = 1'b0;

    // Reset, then idle with no load
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("idle");

    // Single word 0xA5
    q_words.push_back(8'hA5);
    run_stream(14);
    analyze();
    check("a5.first",  first,  32'd2);
    check("a5.runlen", runlen, 32'd8);
    check("a5.bits",   bits,   32'h0000_00A5);
    check("a5.done",   dones,  32'h0000_0001);
    check("a5.ndone",  ndone,  32'd1);
    check_idle("a5.after");

    // Back-to-back 0xFF then 0x00
    q_words.push_back(8'hFF);
    q_words.push_back(8'h00);
    run_stream(22);
    analyze();
    check("b2b.first",  first,  32'd2);
    check("b2b.runlen", runlen, 32'd16);
    check("b2b.bits",   bits,   32'h0000_FF00);
    check("b2b.done",   dones,  32'h0000_0101);

    // Hold full: 0x3C waits while 0x22 sits in the holding register
    q_words.push_back(8'h11);
    q_words.push_back(8'h22);
    q_words.push_back(8'h3C);
    run_stream(30);
    analyze();
    check("hold.runlen",  runlen,  32'd24);
    check("hold.bits",    bits,    32'h0011_223C);
    check("hold.done",    dones,   32'h0001_0101);
    check("hold.blocked", blocked, 32'd8);
    check("hold.qempty",  q_words.size(), 32'd0);

    // Reset mid-word after 3 bits of 0x81
    q_words.push_back(8'h81);
    run_stream(5);
    analyze();
    check("mid.runlen", runlen, 32'd3);
    check("mid.bits",   bits,   32'h0000_0004);
    #2 reset_n = 1'b0;
    #1 check_idle("mid.rst");
    repeat (2) @(negedge clk);
    check_idle("mid.rsthold");
    reset_n = 1'b1;
    run_stream(3);
    analyze();
    check("mid.ndone", ndone, 32'd0);
    q_words.push_back(8'h42);
    run_stream(12);
    analyze();
    check("x42.first", first, 32'd2);
    check("x42.bits",  bits,  32'h0000_0042);
    check("x42.done",  dones, 32'h0000_0001);

    // WIDTH=4 build: 0xB -> 1,0,1,1
    exp4 = 4'b1011;
    @(negedge clk);
    d4_din = 4'hB; d4_valid = 1'b1;
    @(negedge clk);
    d4_valid = 1'b0;
    check("w4.ready_low", {31'd0, d4_ready},   32'd0);
    check("w4.en_pre",    {31'd0, d4_sout_en}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("w4.en%0d", j),   {31'd0, d4_sout_en}, 32'd1);
      check($sformatf("w4.bit%0d", j),  {31'd0, d4_sout},    {31'd0, exp4[3-j]});
      check($sformatf("w4.done%0d", j), {31'd0, d4_done},    (j == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("w4.en_post", {31'd0, d4_sout_en}, 32'd0);
    check("w4.busy",    {31'd0, d4_busy},    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
